// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if
//   Groups the handshake and payload signals of one pipe_stage_reg.
//   WIDTH  payload width in bits.
//   Signals:
//     FLUSH      synchronous squash request, upstream/control -> stage
//     IN_DATA    payload, upstream -> stage
//     IN_VALID   upstream offers IN_DATA
//     IN_READY   stage can accept (registered)
//     OUT_DATA   payload, stage -> downstream (registered)
//     OUT_VALID  OUT_DATA holds a live payload
//     OUT_READY  downstream consumes OUT_DATA this cycle
//     COUNT      occupancy (0, 1 or 2)
//   Modports:
//     master  the environment around the stage (drives inputs, observes outputs)
//     slave   the stage itself
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 32
);
  logic             FLUSH;
  logic [WIDTH-1:0] IN_DATA;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [1:0]       COUNT;

  modport master (
    output FLUSH, IN_DATA, IN_VALID, OUT_READY,
    input  IN_READY, OUT_DATA, OUT_VALID, COUNT
  );

  modport slave (
    input  FLUSH, IN_DATA, IN_VALID, OUT_READY,
    output IN_READY, OUT_DATA, OUT_VALID, COUNT
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Pipeline register between datapath stages with a valid/ready handshake
//   and a one-entry skid buffer. Sustains one transfer per cycle while the
//   downstream is ready; both the data path and the ready path are registered,
//   so there is no combinational path from IN_* to OUT_* or from OUT_READY to
//   IN_READY.
//   Parameters:
//     WIDTH        payload width in bits (>= 1), must match the interface
//     RESET_VALUE  value shown on OUT_DATA (and held in skid) after reset
//   Ports:
//     CLK    rising-edge clock
//     RESET  asynchronous, active-high; clears all state immediately
//     bus    pipe_stage_reg_if.slave: FLUSH, IN_DATA/IN_VALID/IN_READY,
//            OUT_DATA/OUT_VALID/OUT_READY, COUNT
module pipe_stage_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  pipe_stage_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       count_q;

  logic             in_xfer;
  logic             out_xfer;

  // Handshake qualifiers use only registered flags, keeping the ready path
  // free of any dependency on OUT_READY.
  always_comb begin
    in_xfer  = bus.IN_VALID & in_ready_q;
    out_xfer = out_valid_q & bus.OUT_READY;
  end

  // State and all visible flags are updated together so every output comes
  // straight from a flop. FLUSH leaves main/skid data untouched; the stale
  // contents are masked by OUT_VALID=0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= EMPTY;
      main_q      <= RESET_VALUE;
      skid_q      <= RESET_VALUE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
    end else if (bus.FLUSH) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q      <= bus.IN_DATA;
            state       <= BUSY;
            out_valid_q <= 1'b1;
            count_q     <= 2'd1;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_q <= bus.IN_DATA;
          end else if (in_xfer) begin
            skid_q     <= bus.IN_DATA;
            state      <= FULL;
            in_ready_q <= 1'b0;
            count_q    <= 2'd2;
          end else if (out_xfer) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            count_q     <= 2'd0;
          end
        end
        FULL: begin
          // IN_READY is low here, so only the drain of main can happen.
          if (out_xfer) begin
            main_q     <= skid_q;
            state      <= BUSY;
            in_ready_q <= 1'b1;
            count_q    <= 2'd1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          count_q     <= 2'd0;
        end
      endcase
    end
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT_DATA  = main_q;
  assign bus.COUNT     = count_q;

endmodule
